updn_counter_param: RTL and testbench

- Parametrised successor of the team's fixed 8-bit up/down counter with load and enable.
- Generalises width, upper limit and step size, and adds a wrap or saturate mode.
- Adds limit flags, a one-cycle overflow/underflow pulse and a sticky overflow flag.
- Used as the standard counter for timers and credit tracking. The checker that comes with it can be compiled in.

---
 rtl/counter_pkg.sv | 64 ++++++
 rtl/updn_counter_sva.sv | 62 ++++++
 rtl/updn_counter_param.sv | 105 ++++++++++
 tb/tb_updn_counter_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and next-count arithmetic for updn_counter_param and its checker.
// The arithmetic is written once here so the RTL and the checker cannot drift apart.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
    typedef enum logic {CNT_DOWN, CNT_UP} cnt_dir_e;

    // Widest counter supported; callers zero-extend into this width.
    localparam int CNT_MAX_W = 32;

    // Returns {ovf, next}. One spare bit keeps the limit compare free of truncation.
    function automatic logic [CNT_MAX_W:0] next_count(
        input logic [CNT_MAX_W-1:0] cur,
        input logic [CNT_MAX_W-1:0] step,
        input logic [CNT_MAX_W-1:0] max,
        input cnt_mode_e            mode,
        input cnt_dir_e             dir
    );
        logic [CNT_MAX_W:0]   wideCur;
        logic [CNT_MAX_W:0]   wideStep;
        logic [CNT_MAX_W:0]   wideRange;
        logic [CNT_MAX_W:0]   tmp;
        logic [CNT_MAX_W-1:0] nxt;
        logic                 ovf;

        wideCur   = {1'b0, cur};
        wideStep  = {1'b0, step};
        wideRange = {1'b0, max} + 1'b1;
        tmp       = '0;
        nxt       = cur;
        ovf       = 1'b0;

        if (dir == CNT_UP) begin
            tmp = wideCur + wideStep;
            if (tmp > {1'b0, max}) begin
                ovf = 1'b1;
                if (mode == CNT_SAT) begin
                    nxt = max;
                end else begin
                    tmp = tmp - wideRange;
                    nxt = tmp[CNT_MAX_W-1:0];
                end
            end else begin
                nxt = tmp[CNT_MAX_W-1:0];
            end
        end else begin
            if (wideCur >= wideStep) begin
                tmp = wideCur - wideStep;
                nxt = tmp[CNT_MAX_W-1:0];
            end else begin
                ovf = 1'b1;
                if (mode == CNT_SAT) begin
                    nxt = '0;
                end else begin
                    tmp = wideCur + wideRange - wideStep;
                    nxt = tmp[CNT_MAX_W-1:0];
                end
            end
        end

        return {ovf, nxt};
    endfunction

endpackage

// File: rtl/updn_counter_sva.sv
// Port-only protocol checker for updn_counter_param, bound in by the top when
// UPDN_COUNTER_SVA_EN is defined.
module updn_counter_sva
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP     = 1,
    parameter int unsigned     SAT_MODE = 0
) (
    input logic             clk,
    input logic             rst_,
    input logic             ld_cnt_,
    input logic             updn_cnt,
    input logic             count_enb,
    input logic [WIDTH-1:0] data_in,
    input logic [WIDTH-1:0] data_out,
    input logic             at_max,
    input logic             at_min,
    input logic             ovf,
    input logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam cnt_mode_e MODE = (SAT_MODE != 0) ? CNT_SAT : CNT_WRAP;

    logic [CNT_MAX_W:0] expRes;
    logic [WIDTH-1:0]   expCount;
    logic               expOvf;
    logic [WIDTH-1:0]   loadVal;

    assign expRes   = next_count(CNT_MAX_W'(data_out), CNT_MAX_W'(STEP_W), CNT_MAX_W'(MAX_W),
                                 MODE, cnt_dir_e'(updn_cnt));
    assign expCount = expRes[WIDTH-1:0];
    assign expOvf   = expRes[CNT_MAX_W];
    assign loadVal  = (data_in > MAX_W) ? MAX_W : data_in;

    chkReset: assert property (@(posedge clk) !rst_ |=> (data_out == '0) && !ovf)
        else $error("[SVA] %0t chkReset failed", $stime);

    chkHold: assert property (@(posedge clk) disable iff (!rst_)
        ld_cnt_ && !count_enb |=> $stable(data_out))
        else $error("[SVA] %0t chkHold failed", $stime);

    chkLoad: assert property (@(posedge clk) disable iff (!rst_)
        !ld_cnt_ |=> data_out == $past(loadVal))
        else $error("[SVA] %0t chkLoad failed", $stime);

    chkCount: assert property (@(posedge clk) disable iff (!rst_)
        ld_cnt_ && count_enb |=> (data_out == $past(expCount)) && (ovf == $past(expOvf)))
        else $error("[SVA] %0t chkCount failed", $stime);

    chkSticky: assert property (@(posedge clk) disable iff (!rst_)
        $fell(ovf_sticky) |-> $past(!rst_ || !ld_cnt_))
        else $error("[SVA] %0t chkSticky failed", $stime);

    chkFlags: assert property (@(posedge clk)
        (at_max == (data_out == MAX_W)) && (at_min == (data_out == '0)))
        else $error("[SVA] %0t chkFlags failed", $stime);

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate mode and overflow flags.
// Define UPDN_COUNTER_SVA_EN to compile in the updn_counter_sva checker.
module updn_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP     = 1,
    parameter int unsigned     SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_cnt_,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam cnt_mode_e MODE = (SAT_MODE != 0) ? CNT_SAT : CNT_WRAP;

    if (WIDTH == 0 || WIDTH > CNT_MAX_W) begin : gBadWidth
        $error("updn_counter_param: WIDTH must be 1..%0d", CNT_MAX_W);
    end
    if (STEP == 0) begin : gStepZero
        $error("updn_counter_param: STEP must not be 0");
    end
    if (STEP > MAX_VAL) begin : gStepBig
        $error("updn_counter_param: STEP exceeds MAX_VAL");
    end
    if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : gMaxBig
        $error("updn_counter_param: MAX_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               sticky_q, sticky_d;
    logic [CNT_MAX_W:0] stepRes;
    logic               stepRes_unused;

    assign stepRes = next_count(CNT_MAX_W'(count_q), CNT_MAX_W'(STEP_W), CNT_MAX_W'(MAX_W),
                                MODE, cnt_dir_e'(updn_cnt));
    // Upper result bits are always zero for narrow counters.
    assign stepRes_unused = ^stepRes;

    always_comb begin
        count_d  = count_q;
        ovf_d    = 1'b0;
        sticky_d = sticky_q;
        if (!ld_cnt_) begin
            count_d  = (data_in > MAX_W) ? MAX_W : data_in;
            sticky_d = 1'b0;
        end else if (count_enb) begin
            count_d  = stepRes[WIDTH-1:0];
            ovf_d    = stepRes[CNT_MAX_W];
            sticky_d = sticky_q | stepRes[CNT_MAX_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            count_q  <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign data_out   = count_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
    assign at_max     = (count_q == MAX_W);
    assign at_min     = (count_q == '0);

`ifdef UPDN_COUNTER_SVA_EN
    updn_counter_sva #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .STEP     (STEP),
        .SAT_MODE (SAT_MODE)
    ) uSva (
        .clk        (clk),
        .rst_       (rst_),
        .ld_cnt_    (ld_cnt_),
        .updn_cnt   (updn_cnt),
        .count_enb  (count_enb),
        .data_in    (data_in),
        .data_out   (data_out),
        .at_max     (at_max),
        .at_min     (at_min),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky)
    );
`endif

endmodule

// File: tb/tb_updn_counter_param.sv
// Testbench for updn_counter_param: three configurations (wrap, saturate, full-width)
// share one control stream and are compared each cycle against a behavioural model.
module tb_updn_counter_param;

    logic       clk;
    logic       rst_;
    logic       ld_cnt_;
    logic       updn_cnt;
    logic       count_enb;
    logic [7:0] din8;
    logic [3:0] din4;

    logic [7:0] outWrap, outSat;
    logic [3:0] outFull;
    logic       maxWrap, minWrap, ovfWrap, stWrap;
    logic       maxSat, minSat, ovfSat, stSat;
    logic       maxFull, minFull, ovfFull, stFull;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycle       = 0;

    // Model state, one slot per configuration: 0 = wrap, 1 = saturate, 2 = full width
    int mCnt [3];
    bit mOvf [3];
    bit mSt  [3];
    int mMax  [3] = '{200, 200, 15};
    int mStep [3] = '{3, 3, 1};
    bit mSat  [3] = '{1'b0, 1'b1, 1'b0};
    int mMask [3] = '{255, 255, 15};

    assign din4 = din8[3:0];

    updn_counter_param #(.WIDTH(8), .MAX_VAL(200), .STEP(3), .SAT_MODE(0)) dutWrap (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .data_in(din8), .data_out(outWrap), .at_max(maxWrap), .at_min(minWrap),
        .ovf(ovfWrap), .ovf_sticky(stWrap));

    updn_counter_param #(.WIDTH(8), .MAX_VAL(200), .STEP(3), .SAT_MODE(1)) dutSat (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .data_in(din8), .data_out(outSat), .at_max(maxSat), .at_min(minSat),
        .ovf(ovfSat), .ovf_sticky(stSat));

    updn_counter_param #(.WIDTH(4), .MAX_VAL(15), .STEP(1), .SAT_MODE(0)) dutFull (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .data_in(din4), .data_out(outFull), .at_max(maxFull), .at_min(minFull),
        .ovf(ovfFull), .ovf_sticky(stFull));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", tag, cycle, observed, expected);
        end
    endtask

    // Counter rules restated with plain integers
    task automatic modelUpdate(input int k, input bit r, input bit l, input bit u, input bit e,
                               input int d);
        int v;
        if (!r) begin
            mCnt[k] = 0; mOvf[k] = 0; mSt[k] = 0;
        end else if (!l) begin
            v = d & mMask[k];
            mCnt[k] = (v > mMax[k]) ? mMax[k] : v;
            mOvf[k] = 0; mSt[k] = 0;
        end else if (e) begin
            if (u) begin
                v = mCnt[k] + mStep[k];
                mOvf[k] = (v > mMax[k]);
                if (mOvf[k]) v = mSat[k] ? mMax[k] : v - (mMax[k] + 1);
            end else begin
                v = mCnt[k] - mStep[k];
                mOvf[k] = (v < 0);
                if (mOvf[k]) v = mSat[k] ? 0 : v + (mMax[k] + 1);
            end
            mCnt[k] = v;
            mSt[k]  = mSt[k] | mOvf[k];
        end else begin
            mOvf[k] = 0;
        end
    endtask

    task automatic checkDut(input int k, input string name, input int cnt, input bit amax,
                            input bit amin, input bit o, input bit st);
        checkOutput({name, "_count"}, cnt, mCnt[k]);
        checkOutput({name, "_at_max"}, int'(amax), int'(mCnt[k] == mMax[k]));
        checkOutput({name, "_at_min"}, int'(amin), int'(mCnt[k] == 0));
        checkOutput({name, "_ovf"}, int'(o), int'(mOvf[k]));
        checkOutput({name, "_sticky"}, int'(st), int'(mSt[k]));
    endtask

    // Drive one cycle, advance the model on the edge, then compare 1 time unit later
    task automatic applyStimulus(input bit r, input bit l, input bit u, input bit e, input int d);
        rst_ = r; ld_cnt_ = l; updn_cnt = u; count_enb = e; din8 = d[7:0];
        @(posedge clk);
        for (int k = 0; k < 3; k++) modelUpdate(k, r, l, u, e, d);
        #1;
        cycle++;
        checkDut(0, "wrap", int'(outWrap), maxWrap, minWrap, ovfWrap, stWrap);
        checkDut(1, "sat", int'(outSat), maxSat, minSat, ovfSat, stSat);
        checkDut(2, "full", int'(outFull), maxFull, minFull, ovfFull, stFull);
    endtask

    initial begin
        int pulses;
        int picks [8] = '{0, 1, 2, 7, 199, 200, 201, 255};
        rst_ = 1'b0; ld_cnt_ = 1'b1; updn_cnt = 1'b0; count_enb = 1'b0; din8 = '0;

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("reset_count", int'(outWrap), 0);

        // Reset in the middle of an up-count sequence
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 1, 0);
        checkOutput("midcount_value", int'(outWrap), 15);
        applyStimulus(0, 1, 1, 1, 0);
        checkOutput("midcount_reset", int'(outWrap), 0);

        // Load clamping and load priority over counting
        applyStimulus(1, 0, 1, 0, 250);
        checkOutput("clamp_value", int'(outWrap), 200);
        checkOutput("clamp_at_max", int'(maxWrap), 1);
        applyStimulus(1, 0, 1, 1, 7);
        checkOutput("load_over_count", int'(outWrap), 7);
        checkOutput("load_no_ovf", int'(ovfWrap), 0);

        // Wrap up from 199, sticky holds until the next load
        applyStimulus(1, 0, 1, 0, 199);
        applyStimulus(1, 1, 1, 1, 199);
        checkOutput("wrap_up_value", int'(outWrap), 1);
        checkOutput("wrap_up_ovf", int'(ovfWrap), 1);
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("wrap_ovf_pulse_ends", int'(ovfWrap), 0);
        checkOutput("wrap_sticky_holds", int'(stWrap), 1);
        applyStimulus(1, 0, 1, 0, 2);
        checkOutput("load_clears_sticky", int'(stWrap), 0);

        // Saturate down from 2, repeated pulses at the floor, then hold
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("sat_down_value", int'(outSat), 0);
        checkOutput("sat_down_ovf", int'(ovfSat), 1);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("sat_floor_ovf_again", int'(ovfSat), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("sat_hold_ovf", int'(ovfSat), 0);
        checkOutput("sat_hold_value", int'(outSat), 0);

        // Hold with direction toggling
        applyStimulus(1, 0, 0, 0, 100);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, i[0], 0, 0);
        checkOutput("hold_value", int'(outWrap), 100);

        // Full-width 4-bit wrap: 16 counts return to zero with a single ovf pulse
        applyStimulus(1, 0, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 1, 1, 0);
            if (ovfFull) pulses++;
        end
        checkOutput("full_wrap_zero", int'(outFull), 0);
        checkOutput("full_ovf_pulses", pulses, 1);

        // Randomised traffic biased toward the limits
        for (int i = 0; i < 600; i++) begin
            bit r, l, u, e;
            int d;
            r = ($urandom_range(0, 99) >= 3);
            l = ($urandom_range(0, 99) >= 10);
            u = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 99) < 75);
            d = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 7)]
                                            : int'($urandom_range(0, 255));
            applyStimulus(r, l, u, e, d);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
